// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM job scheduler: dimension width, parameter
// defaults, FSM state encodings, the command record and the busy-wait timeout.
package gemm_pkg;

  localparam int DIM_W        = 8;
  localparam int DEPTH_DEFAULT = 4;
  localparam int ID_W_DEFAULT  = 4;
  localparam int ID_MAX_W      = 16;
  localparam int WAIT_TIMEOUT  = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LAUNCH    = 3'd1;
  localparam state_t ST_WAIT_BUSY = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

  // Command record; id is sized for the widest supported job-id.
  typedef struct packed {
    logic [DIM_W-1:0]    k;
    logic [DIM_W-1:0]    m;
    logic [DIM_W-1:0]    n;
    logic [ID_MAX_W-1:0] id;
  } cmd_t;

  function automatic logic has_zero_dim(input logic [DIM_W-1:0] k,
                                        input logic [DIM_W-1:0] m,
                                        input logic [DIM_W-1:0] n);
    return (k == '0) || (m == '0) || (n == '0);
  endfunction

endpackage

// File: rtl/gemm_cmd_fifo.sv
// In-order command FIFO with occupancy count. A push into a full queue is
// dropped (no bypass); a pop from an empty queue is ignored.
module gemm_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gemm_scheduler.sv
// GEMM job scheduler: queues matrix-multiply commands, launches them one at a
// time on the systolic array, times each run and reports a completion record.
module gemm_scheduler import gemm_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int ID_W  = ID_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DIM_W-1:0]       cmd_K,
  input  logic [DIM_W-1:0]       cmd_M,
  input  logic [DIM_W-1:0]       cmd_N,
  input  logic [ID_W-1:0]        cmd_id,
  output logic                   sa_in_valid,
  output logic [DIM_W-1:0]       sa_K,
  output logic [DIM_W-1:0]       sa_M,
  output logic [DIM_W-1:0]       sa_N,
  input  logic                   sa_busy,
  output logic                   done_valid,
  output logic [ID_W-1:0]        done_id,
  output logic [15:0]            done_cycles,
  output logic                   done_err,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   idle
);

  localparam int WIDTH  = 3 * DIM_W + ID_W;
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT) + 1;

  state_t             state;
  logic [WIDTH-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [DIM_W-1:0]   head_k;
  logic [DIM_W-1:0]   head_m;
  logic [DIM_W-1:0]   head_n;
  logic [ID_W-1:0]    head_id;
  logic               head_zero;
  logic [15:0]        cyc_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [ID_W-1:0]    job_id;

  assign head_k    = head[WIDTH-1 -: DIM_W];
  assign head_m    = head[WIDTH-1-DIM_W -: DIM_W];
  assign head_n    = head[ID_W +: DIM_W];
  assign head_id   = head[ID_W-1:0];
  assign head_zero = has_zero_dim(head_k, head_m, head_n);

  assign cmd_ready   = !fifo_full;
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == ST_LAUNCH) ||
                       ((state == ST_IDLE) && !fifo_empty && head_zero);
  assign sa_in_valid = (state == ST_LAUNCH);
  assign done_valid  = (state == ST_DONE);
  assign idle        = (state == ST_IDLE) && fifo_empty;

  gemm_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_K, cmd_M, cmd_N, cmd_id}),
    .rdata (head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Job FSM with run/wait counters and the registered launch and completion records.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sa_K        <= '0;
      sa_M        <= '0;
      sa_N        <= '0;
      job_id      <= '0;
      cyc_cnt     <= '0;
      wait_cnt    <= '0;
      done_id     <= '0;
      done_cycles <= '0;
      done_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_zero) begin
              done_id     <= head_id;
              done_cycles <= '0;
              done_err    <= 1'b0;
              state       <= ST_DONE;
            end else begin
              sa_K  <= head_k;
              sa_M  <= head_m;
              sa_N  <= head_n;
              state <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          job_id   <= head_id;
          cyc_cnt  <= '0;
          wait_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (sa_busy) begin
            cyc_cnt <= cyc_cnt + 16'd1;
            state   <= ST_RUN;
          end else if (wait_cnt == WAIT_W'(WAIT_TIMEOUT - 1)) begin
            done_id     <= job_id;
            done_cycles <= '0;
            done_err    <= 1'b1;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_RUN: begin
          if (sa_busy) begin
            if (cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
          end else begin
            done_id     <= job_id;
            done_cycles <= cyc_cnt;
            done_err    <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_scheduler.sv
// Scoreboard bench for gemm_scheduler: stimulus queues expected launches and
// completions, a negedge monitor pops and compares whenever the DUT reports.
module tb_gemm_scheduler;
  import gemm_pkg::*;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [7:0]             cmd_K = '0;
  logic [7:0]             cmd_M = '0;
  logic [7:0]             cmd_N = '0;
  logic [ID_W-1:0]        cmd_id = '0;
  logic                   sa_in_valid;
  logic [7:0]             sa_K;
  logic [7:0]             sa_M;
  logic [7:0]             sa_N;
  logic                   sa_busy = 1'b0;
  logic                   done_valid;
  logic [ID_W-1:0]        done_id;
  logic [15:0]            done_cycles;
  logic                   done_err;
  logic [$clog2(DEPTH):0] queue_count;
  logic                   idle;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [15:0]     cyc;
    logic            err;
    bit              chk_lat;
  } exp_done_t;

  exp_done_t   exp_done[$];
  logic [23:0] exp_launch[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          busy_len = 0;
  int          cycle_cnt = 0;
  int          launch_cycle = 0;
  logic [23:0] mon_dims;
  exp_done_t   mon_exp;

  gemm_scheduler #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_K       (cmd_K),
    .cmd_M       (cmd_M),
    .cmd_N       (cmd_N),
    .cmd_id      (cmd_id),
    .sa_in_valid (sa_in_valid),
    .sa_K        (sa_K),
    .sa_M        (sa_M),
    .sa_N        (sa_N),
    .sa_busy     (sa_busy),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .done_cycles (done_cycles),
    .done_err    (done_err),
    .queue_count (queue_count),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic cmd_t mk(input logic [7:0] k, input logic [7:0] m,
                              input logic [7:0] n, input logic [15:0] id);
    cmd_t c;
    c.k  = k;
    c.m  = m;
    c.n  = n;
    c.id = id;
    return c;
  endfunction

  // Queue the expected outcome, then hold the command until it is accepted.
  task automatic applyStimulus(input cmd_t c);
    exp_done_t e;
    bit        accepted;
    e.id = c.id[ID_W-1:0];
    if (has_zero_dim(c.k, c.m, c.n)) begin
      e.cyc     = 16'd0;
      e.err     = 1'b0;
      e.chk_lat = 1'b0;
    end else begin
      exp_launch.push_back({c.k, c.m, c.n});
      e.err     = (busy_len == 0);
      e.chk_lat = (busy_len == 0);
      if (busy_len == 0)          e.cyc = 16'd0;
      else if (busy_len > 65535)  e.cyc = 16'hFFFF;
      else                        e.cyc = 16'(busy_len);
    end
    exp_done.push_back(e);
    cmd_K     = c.k;
    cmd_M     = c.m;
    cmd_N     = c.n;
    cmd_id    = c.id[ID_W-1:0];
    cmd_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) checkOutput("cmd accepted", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_done.size() == 0 && exp_launch.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("scoreboard drained", 32'(exp_done.size() + exp_launch.size()), 32'd0);
  endtask

  task automatic waitBusy(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sa_busy) break;
      @(negedge clk);
    end
    checkOutput("sa_busy seen", 32'(sa_busy), 32'd1);
  endtask

  // Systolic array model: raises busy the cycle after a launch for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && sa_in_valid && busy_len > 0) begin
        @(posedge clk);
        #1 sa_busy = 1'b1;
        for (int i = 0; i < busy_len && rst_n; i++) @(posedge clk);
        #1 sa_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT launches or completes a job.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sa_in_valid) begin
        launch_cycle = cycle_cnt;
        if (exp_launch.size() == 0) begin
          checkOutput("unexpected launch", 32'd1, 32'd0);
        end else begin
          mon_dims = exp_launch.pop_front();
          checkOutput("launch dims", {8'd0, sa_K, sa_M, sa_N}, {8'd0, mon_dims});
        end
      end
      if (done_valid) begin
        if (exp_done.size() == 0) begin
          checkOutput("unexpected done", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_done.pop_front();
          checkOutput("done_id", 32'(done_id), 32'(mon_exp.id));
          checkOutput("done_cycles", 32'(done_cycles), 32'(mon_exp.cyc));
          checkOutput("done_err", 32'(done_err), 32'(mon_exp.err));
          if (mon_exp.chk_lat)
            checkOutput("timeout latency", 32'(cycle_cnt - launch_cycle), 32'd5);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset idle", 32'(idle), 32'd1);
    checkOutput("reset queue_count", 32'(queue_count), 32'd0);
    checkOutput("reset sa_in_valid", 32'(sa_in_valid), 32'd0);
    checkOutput("reset sa dims", {8'd0, sa_K, sa_M, sa_N}, 32'd0);
    checkOutput("reset done_valid", 32'(done_valid), 32'd0);
    checkOutput("reset done record", {11'd0, done_id, done_cycles, done_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job, launch latency, then a push landing on the launch pop.
    busy_len = 20;
    applyStimulus(mk(8'd4, 8'd4, 8'd4, 16'd3));
    checkOutput("no launch yet", 32'(sa_in_valid), 32'd0);
    checkOutput("not idle with job", 32'(idle), 32'd0);
    checkOutput("count after push", 32'(queue_count), 32'd1);
    @(negedge clk);
    checkOutput("launch latency", 32'(sa_in_valid), 32'd1);
    checkOutput("count at launch", 32'(queue_count), 32'd1);
    applyStimulus(mk(8'd2, 8'd3, 8'd5, 16'd5));
    checkOutput("count push+pop", 32'(queue_count), 32'd1);
    waitDrain(200);
    checkOutput("sa dims held", {8'd0, sa_K, sa_M, sa_N}, {8'd0, 8'd2, 8'd3, 8'd5});
    checkOutput("done_id held", 32'(done_id), 32'd5);

    // Zero dimension completes without a launch.
    applyStimulus(mk(8'd5, 8'd0, 8'd3, 16'd7));
    waitDrain(50);
    checkOutput("sa dims after zero job", {8'd0, sa_K, sa_M, sa_N}, {8'd0, 8'd2, 8'd3, 8'd5});

    // Fill the queue behind a running job; ordering checked by the scoreboard.
    busy_len = 12;
    applyStimulus(mk(8'd1, 8'd1, 8'd1, 16'd9));
    waitBusy(50);
    for (int i = 0; i < 4; i++) applyStimulus(mk(8'(i + 1), 8'd2, 8'd3, 16'(i)));
    checkOutput("cmd_ready when full", 32'(cmd_ready), 32'd0);
    checkOutput("count when full", 32'(queue_count), 32'd4);
    applyStimulus(mk(8'd5, 8'd2, 8'd3, 16'd4));
    waitDrain(400);

    // Array never goes busy: timeout error.
    busy_len = 0;
    applyStimulus(mk(8'd3, 8'd3, 8'd3, 16'd2));
    waitDrain(50);

    // Long run saturates the cycle counter.
    busy_len = 70000;
    applyStimulus(mk(8'd8, 8'd8, 8'd8, 16'd1));
    waitDrain(71000);

    // Reset during RUN discards the running and the queued job.
    busy_len = 50;
    applyStimulus(mk(8'd6, 8'd6, 8'd6, 16'd4));
    applyStimulus(mk(8'd7, 8'd7, 8'd7, 16'd6));
    waitBusy(50);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    exp_done.delete();
    exp_launch.delete();
    #1;
    checkOutput("mid reset sa_in_valid", 32'(sa_in_valid), 32'd0);
    checkOutput("mid reset done_valid", 32'(done_valid), 32'd0);
    checkOutput("mid reset queue_count", 32'(queue_count), 32'd0);
    checkOutput("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid reset idle", 32'(idle), 32'd1);
    checkOutput("mid reset sa dims", {8'd0, sa_K, sa_M, sa_N}, 32'd0);
    checkOutput("mid reset done record", {11'd0, done_id, done_cycles, done_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idle after reset", 32'(idle), 32'd1);
    checkOutput("count after reset", 32'(queue_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
